// File: rtl/lsu_misalign_sequencer.sv
// Splits misaligned W/H/HU accesses into per-byte memory accesses between the
// core's load/store path and byte-addressed data memory; aligned traffic is combinational.
module lsu_misalign_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_ctrl,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd,
    output logic [CNT_WIDTH-1:0]  split_count,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPLIT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] CTRL_W  = 3'b000;
    localparam logic [2:0] CTRL_HU = 3'b001;
    localparam logic [2:0] CTRL_H  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b011;
    localparam logic [2:0] CTRL_B  = 3'b100;

    logic [1:0]            state;
    logic [1:0]            cnt;
    logic [1:0]            last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            ctrl_q;
    logic                  we_q;
    logic [31:0]           buf_q;
    logic                  req_mis;
    logic                  start;

    assign req_mis = ((req_ctrl == CTRL_W) && (req_addr[1:0] != 2'b00)) ||
                     (((req_ctrl == CTRL_H) || (req_ctrl == CTRL_HU)) && req_addr[0]);

    // Handshake: a request is accepted in the cycle req_valid is high and stall is low;
    // a misaligned request raises stall until the DONE cycle, where the core may advance.
    assign start     = (state == S_IDLE) && req_valid && req_mis;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            last_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ctrl_q      <= 3'b000;
            we_q        <= 1'b0;
            buf_q       <= '0;
            split_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        ctrl_q  <= req_ctrl;
                        we_q    <= req_we;
                        last_q  <= (req_ctrl == CTRL_W) ? 2'd3 : 2'd1;
                        cnt     <= 2'd0;
                        buf_q   <= '0;
                        state   <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    if (!we_q) begin
                        buf_q[{cnt, 3'b000} +: 8] <= mem_rd[7:0];
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == last_q) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (split_count != {CNT_WIDTH{1'b1}}) begin
                        split_count <= split_count + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = 1'b0;
        rdata    = mem_rd;
        mem_we   = req_valid & req_we;
        mem_ctrl = req_ctrl;
        mem_addr = req_addr;
        mem_wd   = req_wdata;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stall  = 1'b1;
                    mem_we = 1'b0;
                end
            end
            S_SPLIT: begin
                stall    = 1'b1;
                mem_addr = addr_q + ADDR_WIDTH'(cnt);
                mem_ctrl = we_q ? CTRL_B : CTRL_BU;
                mem_wd   = wdata_q >> {cnt, 3'b000};
                mem_we   = we_q;
            end
            S_DONE: begin
                mem_we   = 1'b0;
                mem_addr = addr_q;
                mem_ctrl = ctrl_q;
                mem_wd   = wdata_q;
                if (we_q) begin
                    rdata = 32'd0;
                end else begin
                    case (ctrl_q)
                        CTRL_H:  rdata = {{16{buf_q[15]}}, buf_q[15:0]};
                        CTRL_HU: rdata = {16'd0, buf_q[15:0]};
                        default: rdata = buf_q;
                    endcase
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_misalign_sequencer.sv
// Bench for lsu_misalign_sequencer: directed table, reset/saturation sequences and
// randomized accesses against a byte-level memory reference model.
module tb_lsu_misalign_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, mem_we;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
    logic [2:0]  mem_ctrl;
    logic [15:0] split_count;
    logic [1:0]  dbg_state;
    logic        stall2, mem_we2;
    logic [31:0] rdata2, mem_addr2, mem_wd2;
    logic [2:0]  mem_ctrl2;
    logic [1:0]  split_count2;
    logic [1:0]  dbg_state2;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] got_addr_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        chk_rd;
        int          exp_stall;
    } vec_t;
    vec_t vecs[$];

    lsu_misalign_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .mem_we(mem_we), .mem_ctrl(mem_ctrl),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .split_count(split_count), .dbg_state(dbg_state)
    );

    lsu_misalign_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall2), .rdata(rdata2), .mem_we(mem_we2), .mem_ctrl(mem_ctrl2),
        .mem_addr(mem_addr2), .mem_wd(mem_wd2), .mem_rd(mem_rd),
        .split_count(split_count2), .dbg_state(dbg_state2)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Byte memory, indexed by the low 8 address bits; combinational read.
    always_comb begin
        logic [7:0] a;
        a = mem_addr[7:0];
        mem_rd = 32'd0;
        case (mem_ctrl)
            3'b000: mem_rd = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
            3'b001: mem_rd = {16'd0, mem[8'(a + 8'd1)], mem[a]};
            3'b010: mem_rd = {{16{mem[8'(a + 8'd1)][7]}}, mem[8'(a + 8'd1)], mem[a]};
            3'b011: mem_rd = {24'd0, mem[a]};
            3'b100: mem_rd = {{24{mem[a][7]}}, mem[a]};
            default: mem_rd = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_ctrl)
                3'b000: for (int i = 0; i < 4; i++) mem[8'(mem_addr[7:0] + 8'(i))] = mem_wd[8*i +: 8];
                3'b001, 3'b010: for (int i = 0; i < 2; i++) mem[8'(mem_addr[7:0] + 8'(i))] = mem_wd[8*i +: 8];
                3'b011, 3'b100: mem[mem_addr[7:0]] = mem_wd[7:0];
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Driver: present one access, hold it until stall drops, then release after that edge.
    task automatic do_access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] wd, input logic scramble,
                             output logic [31:0] got_rd, output int stalls, output logic timeout);
        req_valid = 1'b1;
        req_we = we;
        req_ctrl = ctrl;
        req_addr = addr;
        req_wdata = wd;
        got_addr_q.delete();
        got_rd = '0;
        stalls = 0;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) begin
                got_rd = rdata;
                timeout = 1'b0;
                break;
            end
            stalls++;
            if (mem_ctrl == 3'b011 || mem_ctrl == 3'b100) got_addr_q.push_back(mem_addr);
            if (scramble) begin
                @(posedge clk);
                #1;
                req_valid = 1'($urandom_range(0, 1));
                req_we = 1'($urandom_range(0, 1));
                req_ctrl = 3'($urandom_range(0, 7));
                req_addr = $urandom;
                req_wdata = $urandom;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_addrs(input string name, input logic [31:0] addr, input int nb);
        exp_q.delete();
        for (int i = 0; i < nb; i++) exp_q.push_back(addr + 32'(i));
        check({name, "_naddr"}, 32'(got_addr_q.size()), 32'(exp_q.size()));
        if (got_addr_q.size() == exp_q.size())
            for (int i = 0; i < nb; i++) check({name, "_addr"}, got_addr_q[i], exp_q[i]);
    endtask

    function automatic int ctrl_bytes(input logic [2:0] c);
        case (c)
            3'b000: return 4;
            3'b001, 3'b010: return 2;
            3'b011, 3'b100: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a);
        logic [31:0] v;
        int nb;
        nb = ctrl_bytes(c);
        v = 0;
        for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[8'(a[7:0] + 8'(i))]) << (8 * i));
        if (c == 3'b010 && v[15]) v = v - 32'h10000;
        if (c == 3'b100 && v[7]) v = v - 32'h100;
        return v;
    endfunction

    initial begin
        logic [31:0] got;
        int          st;
        logic        to;
        int          exp_cnt;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h44; mem[8'h11] = 8'h33; mem[8'h12] = 8'h22; mem[8'h13] = 8'h11;
        mem[8'h33] = 8'h80; mem[8'h34] = 8'hFF;
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;

        apply_reset();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_count", 32'(split_count), 32'd0);
        check("rst_count2", 32'(split_count2), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);

        //              we    ctrl    addr           wd             exp_rd         chk  stall
        vecs.push_back('{1'b0, 3'b000, 32'h00000010, 32'h0,        32'h11223344, 1'b1, 0});
        vecs.push_back('{1'b1, 3'b000, 32'h00000021, 32'hAABBCCDD, 32'h00000000, 1'b1, 5});
        vecs.push_back('{1'b0, 3'b010, 32'h00000033, 32'h0,        32'hFFFFFF80, 1'b1, 3});
        vecs.push_back('{1'b0, 3'b001, 32'h00000033, 32'h0,        32'h0000FF80, 1'b1, 3});
        vecs.push_back('{1'b0, 3'b000, 32'hFFFFFFFE, 32'h0,        32'h04030201, 1'b1, 5});
        vecs.push_back('{1'b0, 3'b101, 32'h00000010, 32'h0,        32'h00000000, 1'b1, 0});
        vecs.push_back('{1'b1, 3'b010, 32'h00000040, 32'h0000BEEF, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 3'b001, 32'h00000040, 32'h0,        32'h0000BEEF, 1'b1, 0});
        vecs.push_back('{1'b1, 3'b010, 32'h00000045, 32'h00001234, 32'h00000000, 1'b1, 3});
        vecs.push_back('{1'b0, 3'b000, 32'h00000044, 32'h0,        32'h00123400, 1'b1, 0});
        vecs.push_back('{1'b0, 3'b100, 32'h00000033, 32'h0,        32'hFFFFFF80, 1'b1, 0});
        vecs.push_back('{1'b0, 3'b011, 32'h00000034, 32'h0,        32'h000000FF, 1'b1, 0});
        vecs.push_back('{1'b1, 3'b111, 32'h00000010, 32'hFFFFFFFF, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 3'b000, 32'h00000010, 32'h0,        32'h11223344, 1'b1, 0});
        vecs.push_back('{1'b0, 3'b000, 32'h00000022, 32'h0,        32'h00AABBCC, 1'b1, 5});
        vecs.push_back('{1'b0, 3'b000, 32'h00000021, 32'h0,        32'hAABBCCDD, 1'b1, 5});

        exp_cnt = 0;
        foreach (vecs[k]) begin
            do_access(vecs[k].we, vecs[k].ctrl, vecs[k].addr, vecs[k].wd, 1'b0, got, st, to);
            check($sformatf("vec%0d_timeout", k), 32'(to), 32'd0);
            check($sformatf("vec%0d_stall", k), 32'(st), 32'(vecs[k].exp_stall));
            if (vecs[k].chk_rd) check($sformatf("vec%0d_rdata", k), got, vecs[k].exp_rd);
            if (vecs[k].exp_stall > 0) begin
                exp_cnt++;
                check_addrs($sformatf("vec%0d", k), vecs[k].addr, vecs[k].exp_stall - 1);
            end
        end
        check("tbl_count", 32'(split_count), 32'(exp_cnt));
        check("sw_bytes", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]}, 32'hAABBCCDD);

        // Reset in the cnt=2 cycle of a misaligned store: only two bytes land.
        apply_reset();
        req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b000;
        req_addr = 32'h51; req_wdata = 32'h11223344;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_count", 32'(split_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_mem", {mem[8'h54], mem[8'h53], mem[8'h52], mem[8'h51]}, 32'h00003344);
        @(posedge clk);
        #1;

        // Saturation of the narrow counter across back-to-back misaligned loads.
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            do_access(1'b0, 3'b000, 32'h61, 32'h0, 1'b0, got, st, to);
            check($sformatf("sat%0d_stall", k), 32'(st), 32'd5);
            check($sformatf("sat%0d_count2", k), 32'(split_count2), 32'((k > 3) ? 3 : k));
            check($sformatf("sat%0d_count", k), 32'(split_count), 32'(k));
        end

        // Randomized accesses against the byte-level model.
        apply_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        exp_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  c;
            logic [31:0] a, wd, exp_rd;
            int          nb;
            logic        mis;
            we = 1'($urandom_range(0, 1));
            c = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            wd = $urandom;
            nb = ctrl_bytes(c);
            mis = (c == 3'b000 && (a % 4) != 0) || ((c == 3'b001 || c == 3'b010) && (a % 2) != 0);
            exp_rd = we ? 32'd0 : model_load(c, a);
            if (we) for (int i = 0; i < nb; i++) ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
            if (mis) exp_cnt++;
            do_access(we, c, a, wd, 1'($urandom_range(0, 1)), got, st, to);
            check("rnd_timeout", 32'(to), 32'd0);
            check("rnd_stall", 32'(st), mis ? 32'(nb + 1) : 32'd0);
            if (!we || mis) check("rnd_rdata", got, exp_rd);
            if (mis) check_addrs("rnd", a, nb);
            if (n % 16 == 15) begin
                check("rnd_count", 32'(split_count), 32'(exp_cnt));
                check("rnd_count2", 32'(split_count2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
            end
        end
        for (int i = 0; i < 256; i++) check($sformatf("mem[%0h]", i), 32'(mem[i]), 32'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
